dcache_bank_arbiter: RTL
========================

// Module: dcache_bank_arbiter
// PURPOSE
//  Arbitrates the write/fill port (port 0) of the banked data-cache SRAMs between the memory controller and core stores.
//  - The memory controller (MC) performs fill reads and writes; the core performs stores.
//  - Banks are selected by the low word-address bits. Requests that target different banks are granted in the same cycle.
//  - A same-bank conflict is normally won by the MC. A starvation counter guarantees the core store eventually wins.
//  - Tracks MC reads through the fixed SRAM read latency and returns the muxed read data with a valid strobe.
// PARAMETERS
//  NUM_BANKS   2   number of data-cache SRAM banks (power of two)
//  BANK_BITS   1   log2(NUM_BANKS); bank = addr[BANK_BITS-1:0]
//  ADDR_W      10  word address width seen by requesters
//  DATA_W      32  data word width
//  STARVE_MAX  4   consecutive blocked core-store cycles before the core gets priority
//  RD_LAT      2   SRAM read latency in cycles (nce asserted -> data usable)
// PORTS
//  clk            in   1                    clock
//  rst            in   1                    reset, asynchronous, active-high
//  IN_mc_nce      in   1                    MC request, active-low
//  IN_mc_nwe      in   1                    MC write, active-low (1 = read)
//  IN_mc_wm       in   DATA_W/8             MC byte write mask
//  IN_mc_addr     in   ADDR_W               MC word address
//  IN_mc_data     in   DATA_W               MC write data
//  OUT_mc_stall   out  1                    MC request not granted this cycle; MC holds it
//  OUT_mc_rdata   out  DATA_W               MC read data
//  OUT_mc_rvalid  out  1                    OUT_mc_rdata valid
//  IN_core_nwe    in   1                    core store request, active-low
//  IN_core_wm     in   DATA_W/8             core byte mask
//  IN_core_addr   in   ADDR_W               core store word address
//  IN_core_data   in   DATA_W               core store data
//  OUT_core_wbusy out  1                    core store not accepted; core holds it
//  OUT_bank_nce   out  NUM_BANKS            per-bank chip enable, active-low
//  OUT_bank_nwe   out  NUM_BANKS            per-bank write enable, active-low
//  OUT_bank_wm    out  NUM_BANKS*DATA_W/8   per-bank byte mask
//  OUT_bank_addr  out  NUM_BANKS*(ADDR_W-BANK_BITS)  per-bank row address = addr[ADDR_W-1:BANK_BITS]
//  OUT_bank_data  out  NUM_BANKS*DATA_W     per-bank write data
//  IN_bank_rdata  in   NUM_BANKS*DATA_W     per-bank port-0 read data
// BEHAVIOUR
//  - Grant logic is combinational, same cycle as the request. A granted bank receives the winner's nwe/wm/addr/data.
//    Ungranted banks: nce=1, nwe=1, all other bank fields don't-care.
//  - Core store is a write only: bank nwe=0, nce=0. The core cannot read through this port.
//  - Different banks, or only one requester: both/all requests granted, OUT_mc_stall=0, OUT_core_wbusy=0.
//  - Same bank, prio_core=0: MC granted, OUT_core_wbusy=1, starve_cnt increments (saturates at STARVE_MAX).
//  - Same bank, prio_core=1: core granted, OUT_mc_stall=1.
//  - prio_core = (starve_cnt == STARVE_MAX). It is a function of the registered count only, so there is no comb loop.
//  - starve_cnt clears to 0 on any cycle the core store is granted, or when no core store is requested.
//  - Read tracking: pipeline of RD_LAT stages of {valid, bank}. Stage 0 is loaded with {1, bank} when an MC read is granted, else {0, x}.
//  - Last stage drives OUT_mc_rvalid and selects OUT_mc_rdata from IN_bank_rdata[bank]; OUT_mc_rdata = 0 when not valid.
//  - Read-to-valid latency is exactly RD_LAT cycles after the grant cycle. Back-to-back reads are fully pipelined, one per cycle.
//  - A stalled MC read enters no pipeline stage. MC reads and core writes to different banks proceed in parallel.
//  - While rst=1:
//    - All flops clear: starve_cnt=0, all pipeline valids=0.
//    - Outputs forced: OUT_bank_nce=all 1, OUT_bank_nwe=all 1, OUT_mc_stall=1, OUT_core_wbusy=1, OUT_mc_rvalid=0, OUT_mc_rdata=0.
//  - Reset mid-read drops in-flight reads; no rvalid is issued for them after reset is released.
//  - Reset release: first request after rst falls is arbitrated normally with MC priority.
// STRUCTURE
//  - Shared package dcache_pkg:
//    - DCacheReq_t typedef {nce, nwe, wm, addr, data}.
//    - DCacheBankIF_t typedef per-bank port.
//    - Constants NUM_BANKS, BANK_BITS, RD_LAT.
//  - One sub-module: dcache_rd_tracker (RD_LAT-deep {valid, bank} shift register plus output mux).
//  - Grant and starvation logic stay in the top module.
// TESTING
//  1. MC read addr 0x004 (bank 0) only -> bank0 nce=0 nwe=1 row 0x002. rvalid=1 exactly 2 cycles later with bank0 rdata.
//  2. MC write addr 0x010, core store addr 0x021 same cycle -> both granted (bank0 MC, bank1 core); stall=0, wbusy=0.
//  3. MC writes bank 0 every cycle while the core holds a store to addr 0x006:
//     - wbusy=1 for 4 cycles; 5th cycle core granted and mc_stall=1.
//     - Following cycle MC granted again, starve_cnt=0.
//  4. MC reads addrs 0,1,2,3 on consecutive cycles -> rvalid high 4 consecutive cycles, data from banks 0,1,0,1 in order.
//  5. MC read granted, rst pulsed 1 cycle before the data returns:
//     - No rvalid is issued.
//     - All bank nce=1 during rst.
//     - Next read after release returns normally.
//  6. Idle (both nce/nwe=1) -> all bank nce=1, stall=0, wbusy=0, starve_cnt stays 0.

Source files
------------

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared constants and request/bank-port types for the data-cache port-0 arbiter
package dcache_pkg;

    localparam int NUM_BANKS  = 2;
    localparam int BANK_BITS  = 1;
    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 32;
    localparam int WM_W       = DATA_W / 8;
    localparam int ROW_W      = ADDR_W - BANK_BITS;
    localparam int STARVE_MAX = 4;
    localparam int RD_LAT     = 2;
    localparam int CNT_W      = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic              nce;
        logic              nwe;
        logic [WM_W-1:0]   wm;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } DCacheReq_t;

    typedef struct packed {
        logic              nce;
        logic              nwe;
        logic [WM_W-1:0]   wm;
        logic [ROW_W-1:0]  addr;
        logic [DATA_W-1:0] data;
    } DCacheBankIF_t;

endpackage

// File: rtl/dcache_rd_tracker.sv
// rtl/dcache_rd_tracker.sv - follows granted MC reads through the SRAM latency and muxes the returning bank data
module dcache_rd_tracker
    import dcache_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rd_grant,
    input  logic [BANK_BITS-1:0]        rd_bank,
    input  logic [NUM_BANKS*DATA_W-1:0] bank_rdata,
    output logic                        rvalid,
    output logic [DATA_W-1:0]           rdata
);

    logic [RD_LAT-1:0]    vld;
    logic [BANK_BITS-1:0] bnk [RD_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < RD_LAT; i++) bnk[i] <= '0;
        end else begin
            vld[0] <= rd_grant;
            bnk[0] <= rd_bank;
            for (int i = 1; i < RD_LAT; i++) begin
                vld[i] <= vld[i-1];
                bnk[i] <= bnk[i-1];
            end
        end
    end

    assign rvalid = vld[RD_LAT-1];
    assign rdata  = rvalid ? bank_rdata[int'(bnk[RD_LAT-1])*DATA_W +: DATA_W] : '0;

endmodule

// File: rtl/dcache_bank_arbiter.sv
// rtl/dcache_bank_arbiter.sv - per-bank port-0 arbitration between memory-controller fills and core stores
module dcache_bank_arbiter
    import dcache_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        IN_mc_nce,
    input  logic                        IN_mc_nwe,
    input  logic [WM_W-1:0]             IN_mc_wm,
    input  logic [ADDR_W-1:0]           IN_mc_addr,
    input  logic [DATA_W-1:0]           IN_mc_data,
    output logic                        OUT_mc_stall,
    output logic [DATA_W-1:0]           OUT_mc_rdata,
    output logic                        OUT_mc_rvalid,
    input  logic                        IN_core_nwe,
    input  logic [WM_W-1:0]             IN_core_wm,
    input  logic [ADDR_W-1:0]           IN_core_addr,
    input  logic [DATA_W-1:0]           IN_core_data,
    output logic                        OUT_core_wbusy,
    output logic [NUM_BANKS-1:0]        OUT_bank_nce,
    output logic [NUM_BANKS-1:0]        OUT_bank_nwe,
    output logic [NUM_BANKS*WM_W-1:0]   OUT_bank_wm,
    output logic [NUM_BANKS*ROW_W-1:0]  OUT_bank_addr,
    output logic [NUM_BANKS*DATA_W-1:0] OUT_bank_data,
    input  logic [NUM_BANKS*DATA_W-1:0] IN_bank_rdata
);

    DCacheReq_t           mc_r, core_r;
    DCacheBankIF_t        bank_if [NUM_BANKS];
    logic [CNT_W-1:0]     starve_cnt;
    logic [BANK_BITS-1:0] mc_bank, core_bank;
    logic                 mc_req, core_req, same_bank, prio_core, mc_gnt, core_gnt;

    // A core store is always a write, so its request strobe doubles as chip enable.
    assign mc_r   = '{nce: IN_mc_nce, nwe: IN_mc_nwe, wm: IN_mc_wm, addr: IN_mc_addr, data: IN_mc_data};
    assign core_r = '{nce: IN_core_nwe, nwe: 1'b0, wm: IN_core_wm, addr: IN_core_addr, data: IN_core_data};

    assign mc_bank   = mc_r.addr[BANK_BITS-1:0];
    assign core_bank = core_r.addr[BANK_BITS-1:0];

    // prio_core depends only on the registered count, keeping grant logic loop-free.
    assign prio_core = (starve_cnt == CNT_W'(STARVE_MAX));

    always_comb begin
        mc_req    = !rst && !mc_r.nce;
        core_req  = !rst && !core_r.nce;
        same_bank = mc_req && core_req && (mc_bank == core_bank);
        mc_gnt    = mc_req && !(same_bank && prio_core);
        core_gnt  = core_req && !(same_bank && !prio_core);
    end

    assign OUT_mc_stall   = rst || (mc_req && !mc_gnt);
    assign OUT_core_wbusy = rst || (core_req && !core_gnt);

    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_if[b]     = '0;
            bank_if[b].nce = 1'b1;
            bank_if[b].nwe = 1'b1;
            if (mc_gnt && mc_bank == BANK_BITS'(b)) begin
                bank_if[b].nce  = 1'b0;
                bank_if[b].nwe  = mc_r.nwe;
                bank_if[b].wm   = mc_r.wm;
                bank_if[b].addr = mc_r.addr[ADDR_W-1:BANK_BITS];
                bank_if[b].data = mc_r.data;
            end else if (core_gnt && core_bank == BANK_BITS'(b)) begin
                bank_if[b].nce  = 1'b0;
                bank_if[b].nwe  = core_r.nwe;
                bank_if[b].wm   = core_r.wm;
                bank_if[b].addr = core_r.addr[ADDR_W-1:BANK_BITS];
                bank_if[b].data = core_r.data;
            end
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        assign OUT_bank_nce[g]                 = bank_if[g].nce;
        assign OUT_bank_nwe[g]                 = bank_if[g].nwe;
        assign OUT_bank_wm[g*WM_W +: WM_W]     = bank_if[g].wm;
        assign OUT_bank_addr[g*ROW_W +: ROW_W] = bank_if[g].addr;
        assign OUT_bank_data[g*DATA_W +: DATA_W] = bank_if[g].data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            starve_cnt <= '0;
        else if (core_gnt || !core_req)
            starve_cnt <= '0;
        else if (!prio_core)
            starve_cnt <= starve_cnt + CNT_W'(1);
    end

    dcache_rd_tracker u_rd_tracker (
        .clk        (clk),
        .rst        (rst),
        .rd_grant   (mc_gnt && mc_r.nwe),
        .rd_bank    (mc_bank),
        .bank_rdata (IN_bank_rdata),
        .rvalid     (OUT_mc_rvalid),
        .rdata      (OUT_mc_rdata)
    );

endmodule
